// File: rtl/uart_param_core.sv
// uart_param_core: parametrised full-duplex UART with oversampled receiver and valid/ready handshakes
module uart_param_core #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic ODD = (PARITY == 2);

    typedef enum logic [2:0] {IDLE, ALIGN, START, DATA, PAR, STOP} state_t;

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 tick;

    state_t               tx_state_q, tx_state_d;
    logic [TW-1:0]        tx_tcnt_q, tx_tcnt_d;
    logic [BW-1:0]        tx_bcnt_q, tx_bcnt_d;
    logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;
    logic                 tx_ready_q, tx_ready_d;
    logic                 tx_bit_end;

    logic                 s1_q, s2_q;
    state_t               rx_state_q, rx_state_d;
    logic [TW-1:0]        rx_tcnt_q, rx_tcnt_d;
    logic [BW-1:0]        rx_bcnt_q, rx_bcnt_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_perr_q, rx_perr_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 rx_perr_out_q, rx_perr_out_d;
    logic                 rx_ferr_q, rx_ferr_d;
    logic                 rx_ovr_q, rx_ovr_d;
    logic                 rx_done, rx_mid_start, rx_bit_mid;

    assign tick         = (cnt_q == baud_div);
    assign cnt_d        = tick ? '0 : cnt_q + DIV_WIDTH'(1);
    assign tx_bit_end   = tick && (tx_tcnt_q == TW'(OVERSAMPLE - 1));
    assign rx_mid_start = tick && (rx_tcnt_q == TW'(OVERSAMPLE / 2 - 1));
    assign rx_bit_mid   = tick && (rx_tcnt_q == TW'(OVERSAMPLE - 1));

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tcnt_d  = tx_tcnt_q;
        tx_bcnt_d  = tx_bcnt_q;
        tx_sh_d    = tx_sh_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        tx_ready_d = tx_ready_q;
        if (tick && tx_state_q inside {START, DATA, PAR, STOP})
            tx_tcnt_d = tx_bit_end ? '0 : tx_tcnt_q + TW'(1);
        case (tx_state_q)
            IDLE: if (tx_valid && tx_ready_q) begin
                tx_sh_d    = tx_data;
                tx_par_d   = ^tx_data ^ ODD;
                tx_ready_d = 1'b0;
                tx_state_d = ALIGN;
            end
            ALIGN: if (tick) begin
                tx_d       = 1'b0;
                tx_tcnt_d  = '0;
                tx_state_d = START;
            end
            START: if (tx_bit_end) begin
                tx_d       = tx_sh_q[0];
                tx_sh_d    = tx_sh_q >> 1;
                tx_bcnt_d  = '0;
                tx_state_d = DATA;
            end
            DATA: if (tx_bit_end) begin
                if (tx_bcnt_q == BW'(DATA_BITS - 1)) begin
                    tx_d       = (PARITY != 0) ? tx_par_q : 1'b1;
                    tx_bcnt_d  = '0;
                    tx_state_d = (PARITY != 0) ? PAR : STOP;
                end else begin
                    tx_d      = tx_sh_q[0];
                    tx_sh_d   = tx_sh_q >> 1;
                    tx_bcnt_d = tx_bcnt_q + BW'(1);
                end
            end
            PAR: if (tx_bit_end) begin
                tx_d       = 1'b1;
                tx_bcnt_d  = '0;
                tx_state_d = STOP;
            end
            STOP: if (tx_bit_end) begin
                if (tx_bcnt_q == BW'(STOP_BITS - 1)) begin
                    tx_bcnt_d  = '0;
                    tx_ready_d = 1'b1;
                    tx_state_d = IDLE;
                end else begin
                    tx_bcnt_d = tx_bcnt_q + BW'(1);
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_tcnt_d     = rx_tcnt_q;
        rx_bcnt_d     = rx_bcnt_q;
        rx_sh_d       = rx_sh_q;
        rx_perr_d     = rx_perr_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q && !rx_ready;
        rx_perr_out_d = (rx_valid_q && rx_ready) ? 1'b0 : rx_perr_out_q;
        rx_ferr_d     = (rx_valid_q && rx_ready) ? 1'b0 : rx_ferr_q;
        rx_ovr_d      = 1'b0;
        rx_done       = 1'b0;
        if (tick && rx_state_q inside {DATA, PAR, STOP})
            rx_tcnt_d = rx_bit_mid ? '0 : rx_tcnt_q + TW'(1);
        case (rx_state_q)
            IDLE: if (tick && !s2_q) begin
                rx_tcnt_d  = '0;
                rx_perr_d  = 1'b0;
                rx_state_d = START;
            end
            START: if (tick) begin
                rx_tcnt_d = rx_mid_start ? '0 : rx_tcnt_q + TW'(1);
                if (rx_mid_start) begin
                    rx_bcnt_d  = '0;
                    rx_state_d = s2_q ? IDLE : DATA;
                end
            end
            DATA: if (rx_bit_mid) begin
                rx_sh_d = {s2_q, rx_sh_q[DATA_BITS-1:1]};
                if (rx_bcnt_q == BW'(DATA_BITS - 1)) begin
                    rx_bcnt_d  = '0;
                    rx_state_d = (PARITY != 0) ? PAR : STOP;
                end else begin
                    rx_bcnt_d = rx_bcnt_q + BW'(1);
                end
            end
            PAR: if (rx_bit_mid) begin
                rx_perr_d  = s2_q ^ (^rx_sh_q) ^ ODD;
                rx_state_d = STOP;
            end
            STOP: if (rx_bit_mid) begin
                rx_done    = 1'b1;
                rx_state_d = IDLE;
            end
            default: rx_state_d = IDLE;
        endcase
        // A consume in the completion cycle frees the holding register for the new frame
        if (rx_done && (!rx_valid_q || rx_ready)) begin
            rx_data_d     = rx_sh_q;
            rx_perr_out_d = rx_perr_q;
            rx_ferr_d     = !s2_q;
            rx_valid_d    = 1'b1;
        end else if (rx_done) begin
            rx_ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            tx_state_q    <= IDLE;
            tx_tcnt_q     <= '0;
            tx_bcnt_q     <= '0;
            tx_sh_q       <= '0;
            tx_par_q      <= 1'b0;
            tx_q          <= 1'b1;
            tx_ready_q    <= 1'b1;
            s1_q          <= 1'b1;
            s2_q          <= 1'b1;
            rx_state_q    <= IDLE;
            rx_tcnt_q     <= '0;
            rx_bcnt_q     <= '0;
            rx_sh_q       <= '0;
            rx_perr_q     <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_perr_out_q <= 1'b0;
            rx_ferr_q     <= 1'b0;
            rx_ovr_q      <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            tx_state_q    <= tx_state_d;
            tx_tcnt_q     <= tx_tcnt_d;
            tx_bcnt_q     <= tx_bcnt_d;
            tx_sh_q       <= tx_sh_d;
            tx_par_q      <= tx_par_d;
            tx_q          <= tx_d;
            tx_ready_q    <= tx_ready_d;
            s1_q          <= rx;
            s2_q          <= s1_q;
            rx_state_q    <= rx_state_d;
            rx_tcnt_q     <= rx_tcnt_d;
            rx_bcnt_q     <= rx_bcnt_d;
            rx_sh_q       <= rx_sh_d;
            rx_perr_q     <= rx_perr_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_perr_out_q <= rx_perr_out_d;
            rx_ferr_q     <= rx_ferr_d;
            rx_ovr_q      <= rx_ovr_d;
        end
    end

    assign tx            = tx_q;
    assign tx_ready      = tx_ready_q;
    assign rx_data       = rx_data_q;
    assign rx_valid      = rx_valid_q;
    assign rx_parity_err = rx_perr_out_q;
    assign rx_frame_err  = rx_ferr_q;
    assign rx_overrun    = rx_ovr_q;
endmodule

// File: tb/tb_uart_param_core.sv
// tb_uart_param_core: directed bench for an even-parity instance (driven rx) and an odd-parity loopback instance
module tb_uart_param_core;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] baud_div = 16'd1;
    always #5 clk = ~clk;

    logic [7:0] tx_data1 = '0, tx_data2 = '0;
    logic       tx_valid1 = 1'b0, tx_valid2 = 1'b0;
    logic       rx_ready1 = 1'b0, rx_ready2 = 1'b1;
    logic       rx_drv = 1'b1;
    logic       tx_ready1, tx1, rx_valid1, perr1, ferr1, ovr1;
    logic       tx_ready2, tx2, rx_valid2, perr2, ferr2, ovr2;
    logic [7:0] rx_data1, rx_data2;

    uart_param_core #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_WIDTH(16)) dut1 (
        .clk(clk), .rst(rst), .baud_div(baud_div), .tx_data(tx_data1), .tx_valid(tx_valid1),
        .tx_ready(tx_ready1), .tx(tx1), .rx(rx_drv), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .rx_ready(rx_ready1), .rx_parity_err(perr1), .rx_frame_err(ferr1), .rx_overrun(ovr1));

    uart_param_core #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .OVERSAMPLE(16), .DIV_WIDTH(16)) dut2 (
        .clk(clk), .rst(rst), .baud_div(baud_div), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .tx(tx2), .rx(tx2), .rx_data(rx_data2), .rx_valid(rx_valid2),
        .rx_ready(rx_ready2), .rx_parity_err(perr2), .rx_frame_err(ferr2), .rx_overrun(ovr2));

    int checks = 0;
    int fails = 0;
    int ovr1_cnt = 0;
    int ovr2_cnt = 0;
    logic [9:0] rxq[$];
    logic txs [0:399];

    always @(negedge clk) begin
        if (!rst && rx_valid2 && rx_ready2) rxq.push_back({perr2, ferr2, rx_data2});
        if (ovr1) ovr1_cnt++;
        if (ovr2) ovr2_cnt++;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_rx(input logic [7:0] d, input logic pb, input logic sb);
        rx_drv = 1'b0;
        repeat (32) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (32) @(negedge clk);
        end
        rx_drv = pb;
        repeat (32) @(negedge clk);
        rx_drv = sb;
        repeat (24) @(negedge clk);
        rx_drv = 1'b1;
        repeat (40) @(negedge clk);
    endtask

    task automatic consume1();
        rx_ready1 = 1'b1;
        @(negedge clk);
        rx_ready1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (tx1 !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b expected 1", tx1); end
        checks++; if (tx_ready1 !== 1'b1) begin fails++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready1); end
        checks++; if (rx_valid1 !== 1'b0) begin fails++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid1); end
        checks++; if (rx_data1 !== 8'h00) begin fails++; $display("FAIL reset_rx_data: got %h expected 00", rx_data1); end
        checks++; if ({perr1, ferr1, ovr1} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {perr1, ferr1, ovr1}); end
        checks++; if (tx2 !== 1'b1) begin fails++; $display("FAIL reset_tx2: got %b expected 1", tx2); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_tx_frame();
        logic [10:0] exp_bits;
        int n, len, lw;
        exp_bits = {1'b1, 1'b0, 8'hA5, 1'b0};
        tx_data1 = 8'hA5;
        tx_valid1 = 1'b1;
        @(negedge clk);
        tx_valid1 = 1'b0;
        checks++; if (tx_ready1 !== 1'b0) begin fails++; $display("FAIL tx_ready_drop: got %b expected 0", tx_ready1); end
        n = 0;
        while (tx1 === 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (tx1 !== 1'b0) begin fails++; $display("FAIL tx_start_seen: got %b expected 0", tx1); end
        len = 0;
        while (tx_ready1 !== 1'b1 && len < 400) begin txs[len] = tx1; len++; @(negedge clk); end
        checks++; if (len != 352) begin fails++; $display("FAIL tx_frame_len: got %0d expected 352", len); end
        for (int k = 0; k < 11; k++) begin
            checks++;
            if (txs[32*k+16] !== exp_bits[k]) begin
                fails++; $display("FAIL tx_bit%0d: got %b expected %b", k, txs[32*k+16], exp_bits[k]);
            end
        end
        lw = 0;
        for (int i = 0; i < 33; i++) if (txs[i] === 1'b0) lw++;
        checks++; if (lw != 32) begin fails++; $display("FAIL tx_start_width: got %0d expected 32", lw); end
        checks++; if (tx1 !== 1'b1) begin fails++; $display("FAIL tx_idle_after: got %b expected 1", tx1); end
    endtask

    task automatic test_back_to_back();
        int n;
        rxq.delete();
        ovr2_cnt = 0;
        tx_data2 = 8'h3C;
        tx_valid2 = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (tx_ready2 !== 1'b0 && n < 50);
        tx_data2 = 8'hFF;
        while (tx_ready2 !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        @(negedge clk);
        tx_valid2 = 1'b0;
        checks++; if (tx_ready2 !== 1'b0) begin fails++; $display("FAIL b2b_second_capture: got %b expected 0", tx_ready2); end
        n = 0;
        while (rxq.size() < 2 && n < 1500) begin @(negedge clk); n++; end
        checks++; if (rxq.size() != 2) begin fails++; $display("FAIL b2b_count: got %0d expected 2", rxq.size()); end
        if (rxq.size() == 2) begin
            checks++; if (rxq[0] !== {2'b00, 8'h3C}) begin fails++; $display("FAIL b2b_first: got %h expected 03c", rxq[0]); end
            checks++; if (rxq[1] !== {2'b00, 8'hFF}) begin fails++; $display("FAIL b2b_second: got %h expected 0ff", rxq[1]); end
        end
        checks++; if (ovr2_cnt != 0) begin fails++; $display("FAIL b2b_overrun: got %0d expected 0", ovr2_cnt); end
    endtask

    task automatic test_rx_errors();
        send_rx(8'h55, 1'b1, 1'b1);
        checks++; if (rx_valid1 !== 1'b1) begin fails++; $display("FAIL perr_valid: got %b expected 1", rx_valid1); end
        checks++; if (rx_data1 !== 8'h55) begin fails++; $display("FAIL perr_data: got %h expected 55", rx_data1); end
        checks++; if ({perr1, ferr1} !== 2'b10) begin fails++; $display("FAIL perr_flags: got %b expected 10", {perr1, ferr1}); end
        consume1();
        checks++; if (rx_valid1 !== 1'b0) begin fails++; $display("FAIL perr_consume: got %b expected 0", rx_valid1); end
        send_rx(8'h55, 1'b0, 1'b0);
        checks++; if (rx_valid1 !== 1'b1) begin fails++; $display("FAIL ferr_valid: got %b expected 1", rx_valid1); end
        checks++; if (rx_data1 !== 8'h55) begin fails++; $display("FAIL ferr_data: got %h expected 55", rx_data1); end
        checks++; if ({perr1, ferr1} !== 2'b01) begin fails++; $display("FAIL ferr_flags: got %b expected 01", {perr1, ferr1}); end
        consume1();
    endtask

    task automatic test_false_start();
        rx_drv = 1'b0;
        repeat (6) @(negedge clk);
        rx_drv = 1'b1;
        repeat (96) @(negedge clk);
        checks++; if ({rx_valid1, perr1, ferr1} !== 3'b000) begin fails++; $display("FAIL glitch_quiet: got %b expected 000", {rx_valid1, perr1, ferr1}); end
        send_rx(8'h81, 1'b0, 1'b1);
        checks++; if (rx_valid1 !== 1'b1) begin fails++; $display("FAIL glitch_next_valid: got %b expected 1", rx_valid1); end
        checks++; if ({perr1, ferr1, rx_data1} !== {2'b00, 8'h81}) begin fails++; $display("FAIL glitch_next_frame: got %h expected 081", {perr1, ferr1, rx_data1}); end
        consume1();
    endtask

    task automatic test_overrun();
        ovr1_cnt = 0;
        send_rx(8'h11, 1'b0, 1'b1);
        send_rx(8'h22, 1'b0, 1'b1);
        checks++; if (rx_data1 !== 8'h11) begin fails++; $display("FAIL ovr_data_held: got %h expected 11", rx_data1); end
        checks++; if (ovr1_cnt != 1) begin fails++; $display("FAIL ovr_pulse_cycles: got %0d expected 1", ovr1_cnt); end
        checks++; if (rx_valid1 !== 1'b1) begin fails++; $display("FAIL ovr_valid_held: got %b expected 1", rx_valid1); end
        rx_ready1 = 1'b1;
        @(negedge clk);
        checks++; if (rx_valid1 !== 1'b0) begin fails++; $display("FAIL ovr_consume: got %b expected 0", rx_valid1); end
        rx_ready1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        rxq.delete();
        tx_data2 = 8'h5A;
        tx_valid2 = 1'b1;
        @(negedge clk);
        tx_valid2 = 1'b0;
        n = 0;
        while (tx2 === 1'b1 && n < 100) begin @(negedge clk); n++; end
        repeat (32*4 + 16) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (tx2 !== 1'b1) begin fails++; $display("FAIL rstmid_tx: got %b expected 1", tx2); end
        checks++; if (tx_ready2 !== 1'b1) begin fails++; $display("FAIL rstmid_tx_ready: got %b expected 1", tx_ready2); end
        checks++; if (rx_valid2 !== 1'b0) begin fails++; $display("FAIL rstmid_rx_valid: got %b expected 0", rx_valid2); end
        rst = 1'b0;
        repeat (400) @(negedge clk);
        checks++; if (rxq.size() != 0) begin fails++; $display("FAIL rstmid_no_partial: got %0d expected 0", rxq.size()); end
        tx_data2 = 8'h0F;
        tx_valid2 = 1'b1;
        @(negedge clk);
        tx_valid2 = 1'b0;
        n = 0;
        while (rxq.size() < 1 && n < 800) begin @(negedge clk); n++; end
        checks++; if (rxq.size() != 1) begin fails++; $display("FAIL rstmid_fresh_count: got %0d expected 1", rxq.size()); end
        if (rxq.size() == 1) begin
            checks++; if (rxq[0] !== {2'b00, 8'h0F}) begin fails++; $display("FAIL rstmid_fresh_frame: got %h expected 00f", rxq[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_back_to_back();
        test_rx_errors();
        test_false_start();
        test_overrun();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/uart_param_core.md
Name: uart_param_core

Overview:
- Parametrised full-duplex UART core; next generation of the team's fixed 8-bit UART.
- Adds the following over the 8-bit UART:
  - configurable data width, parity mode and stop bits;
  - runtime baud divisor;
  - 16x-oversampled receiver with false-start rejection;
  - valid/ready handshakes on both directions;
  - per-frame parity/frame error flags and an overrun pulse.
- Sits between the bus-side register block and the device pins. Replaces the separate baud-generator/TX/RX/controller split.

Parameters:
- DATA_BITS, 8, payload bits per frame; legal 5..9.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, transmitted stop bits; legal 1..2.
- OVERSAMPLE, 16, oversample ticks per bit; even, >= 4.
- DIV_WIDTH, 16, width of the baud divisor.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- baud_div  in  DIV_WIDTH  oversample tick period minus 1, in clk cycles. Sampled continuously; change only while idle.
- tx_data  in  DATA_BITS  payload to send.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  transmitter idle; accepts a word this cycle.
- tx  out  1  serial output, idle high.
- rx  in  1  asynchronous serial input.
- rx_data  out  DATA_BITS  received payload.
- rx_valid  out  1  rx_data/flags valid; held until consumed.
- rx_ready  in  1  consumer accepts rx_data.
- rx_parity_err  out  1  parity mismatch on the held frame (0 if PARITY=0).
- rx_frame_err  out  1  first stop bit sampled low on the held frame.
- rx_overrun  out  1  one-cycle pulse: a frame completed while rx_valid was high; that frame is dropped.

Behaviour:
- Reset values: tx=1, tx_ready=1, rx_valid=0, rx_data=0, rx_parity_err=0, rx_frame_err=0, rx_overrun=0. All FSMs return to IDLE. Tick counter=0. Synchronizer flops=1.
- Reset mid-frame aborts immediately: tx is driven 1 in the cycle after rst is sampled; the partial RX frame is discarded.

Tick generator:
- Free-running counter. tick asserts for one cycle when count==baud_div, and the counter then wraps to 0.
- Tick period = baud_div+1 clks; baud_div=0 gives a tick every clk.
- Bit time = OVERSAMPLE ticks.

TX FSM: IDLE -> START -> DATA -> PARITY (skipped if PARITY=0) -> STOP -> IDLE.
- Handshake occurs when tx_valid && tx_ready. tx_data is captured and tx_ready drops on the next edge.
- tx goes low at the first tick after capture.
- Each bit is held for exactly OVERSAMPLE ticks; data is sent LSB first.
- Parity bit = XOR of data (even) or its inverse (odd).
- STOP holds tx=1 for STOP_BITS bit times.
- tx_ready rises in the cycle after the final stop tick. Back-to-back words therefore produce no extra idle bit beyond the tick alignment.

RX path:
- rx passes through a 2-flop synchronizer (2 clk latency).
- IDLE: on a tick with synchronized rx=0, enter START and count OVERSAMPLE/2 ticks.
  - At mid-bit, if rx=1 this is a false start: return to IDLE with no output.
  - Otherwise go to DATA.
- DATA samples one bit every OVERSAMPLE ticks at mid-bit, LSB first. DATA_BITS samples are taken.
- PARITY samples one bit (if enabled) and compares it with the computed parity.
- STOP samples one bit; 0 sets frame_err. Only the first stop bit is checked.
- Frame completion, at the stop-bit sample:
  - If rx_valid=0: load rx_data and the flags, and set rx_valid on the next edge.
  - If rx_valid=1: pulse rx_overrun; held data and flags are unchanged.
  - The FSM returns to IDLE at that sample (half a bit early), enabling resync on the next start edge.
- Frames with errors are still delivered, with their flags set.
- rx_valid clears on the edge after rx_valid && rx_ready.
- If consume and completion happen in the same cycle, the new frame is loaded, rx_valid stays 1, and no overrun is signalled.

Widths:
- The parity XOR covers DATA_BITS bits only.
- Bit counters are sized for DATA_BITS and OVERSAMPLE-1. Counters never overflow silently; they reset on every state change.

Test Plan:
- DATA_BITS=8, PARITY=1, STOP_BITS=1, baud_div=1 (bit = 32 clk). Send 0xA5 -> tx shows bits 0,1,0,1,0,0,1,0,1,0,1. Each is 32 clk wide; the frame is 352 clk; tx_ready returns high after it.
- Loop tx to rx, PARITY=2. Send 0x3C then 0xFF back-to-back (tx_valid held) -> rx_valid twice; rx_data 0x3C then 0xFF; both error flags 0.
- Drive rx with 0x55, even-parity frame, parity bit inverted -> rx_data=0x55, rx_parity_err=1. Next, drive stop=0 -> rx_frame_err=1.
- Low glitch on rx lasting 3 ticks (< OVERSAMPLE/2) -> no rx_valid and no errors; the following valid frame 0x81 is received correctly.
- Hold rx_ready=0 and send two frames 0x11 then 0x22 -> rx_data stays 0x11 and rx_overrun pulses exactly 1 cycle. Then assert rx_ready=1 -> rx_valid=0.
- Assert rst mid-TX (during data bit 3) and mid-RX -> next cycle tx=1, tx_ready=1, rx_valid=0. A fresh 0x0F frame then transfers correctly.
